if_stage: RTL and testbench

- Instruction-fetch stage of the 32-bit five-stage pipeline; sits directly upstream of decode.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction and PC+4 into the IF/ID pipeline register, which feeds decode's Instruction and Next_Address inputs.
- Obeys the hazard detector's PCWrite/freeze stall, and redirects and flushes on a taken branch.

---
 rtl/if_stage_if.sv | 41 ++++
 rtl/if_stage.sv | 63 ++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch stage's control inputs, instruction-memory
// bus and IF/ID outputs so the stage and its environment share one port.
//
// Signals:
//   PCWrite        env -> stage  1 = PC may advance, 0 = hold PC
//   freeze         env -> stage  1 = hold IF/ID contents
//   PCSrc          env -> stage  1 = taken branch, redirect and flush
//   Branch_Address env -> stage  branch target (low two bits ignored)
//   imem_data      env -> stage  instruction word at imem_addr (comb read)
//   imem_addr      stage -> env  current PC
//   Instruction    stage -> env  IF/ID instruction, to decode
//   Next_Address   stage -> env  IF/ID PC+4 of that instruction
//   if_valid       stage -> env  1 = IF/ID holds a real fetch, 0 = bubble
//
// Handshake: there is no ready/back-pressure path on the IF/ID side.
// if_valid qualifies Instruction/Next_Address on every cycle; downstream
// stalls are expressed only through PCWrite/freeze, and a flush (PCSrc)
// always forces if_valid low on the following edge.
interface if_stage_if;
  logic        PCWrite;
  logic        freeze;
  logic        PCSrc;
  logic [31:0] Branch_Address;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] Instruction;
  logic [31:0] Next_Address;
  logic        if_valid;

  // Environment side: hazard unit, branch unit, instruction memory, decode.
  modport master (
    output PCWrite, freeze, PCSrc, Branch_Address, imem_data,
    input  imem_addr, Instruction, Next_Address, if_valid
  );

  // Fetch stage side.
  modport slave (
    input  PCWrite, freeze, PCSrc, Branch_Address, imem_data,
    output imem_addr, Instruction, Next_Address, if_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 32-bit five-stage pipeline.
// Holds the PC, drives the instruction-memory address and registers the
// fetched word plus PC+4 into the IF/ID pipeline register for decode.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  if_stage_if.slave (PCWrite, freeze, PCSrc, Branch_Address,
//        imem_data in; imem_addr, Instruction, Next_Address, if_valid out)
//
// Edge priority: reset, then taken branch (redirect + flush, overriding any
// stall), then independent PC (PCWrite) and IF/ID (freeze) updates.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q;
  logic [31:0] next_q;
  logic        valid_q;

  // Wraps silently from FFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= NOP_INSTR;
      next_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (bus.PCSrc) begin
      // The stalled or in-flight fetch is on the wrong path, so a taken
      // branch discards it even when the hazard unit is stalling.
      pc_q    <= {bus.Branch_Address[31:2], 2'b00};
      instr_q <= NOP_INSTR;
      next_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      // PCWrite and freeze act independently; mixed combinations either
      // skip an instruction or re-latch the same one, both intentionally.
      if (bus.PCWrite) begin
        pc_q <= pc_plus4;
      end
      if (!bus.freeze) begin
        instr_q <= bus.imem_data;
        next_q  <= pc_plus4;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.Instruction  = instr_q;
  assign bus.Next_Address = next_q;
  assign bus.if_valid     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan sequence with literal expectations, then
// randomized stimulus, all checked every cycle against a behavioural model
// of the fetch stage (PC plus an IF/ID snapshot) kept in the bench.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2001_0005;
      32'h0000_0004: mem_word = 32'h2002_000A;
      32'h0000_0008: mem_word = 32'h0022_1820;
      default:       mem_word = {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endcase
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  // ---------------- scoreboard bookkeeping ----------------
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What a fetch stage must hold after each edge: the address it will
  // fetch next, and the last word it handed to decode together with the
  // address following that word.
  logic [31:0] m_pc, m_instr, m_next;
  logic        m_valid;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc    = RESET_PC;
      m_instr = NOP_INSTR;
      m_next  = 32'd0;
      m_valid = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (bus.PCSrc) begin
        m_pc    = bus.Branch_Address & 32'hFFFF_FFFC;
        m_instr = NOP_INSTR;
        m_next  = 32'd0;
        m_valid = 1'b0;
      end else begin
        if (!bus.freeze) begin
          m_instr = mem_word(m_pc);
          m_next  = m_pc + 32'd4;
          m_valid = 1'b1;
        end
        if (bus.PCWrite) m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_known) begin
      check("imem_addr",    bus.imem_addr,    m_pc);
      check("Instruction",  bus.Instruction,  m_instr);
      check("Next_Address", bus.Next_Address, m_next);
      check("if_valid",     {31'd0, bus.if_valid}, {31'd0, m_valid});
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic pcw, input logic frz,
                      input logic src, input logic [31:0] ba);
    rst                = r;
    bus.PCWrite        = pcw;
    bus.freeze         = frz;
    bus.PCSrc          = src;
    bus.Branch_Address = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] nxt,
                              input logic vld);
    check({tag, ".addr"},  bus.imem_addr,    addr);
    check({tag, ".instr"}, bus.Instruction,  instr);
    check({tag, ".next"},  bus.Next_Address, nxt);
    check({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, vld});
  endtask

  initial begin
    rst                = 1'b1;
    bus.PCWrite        = 1'b1;
    bus.freeze         = 1'b0;
    bus.PCSrc          = 1'b0;
    bus.Branch_Address = 32'd0;

    // Reset for two cycles.
    step(1, 1, 0, 0, 0);
    expect_state("reset1", 32'h0, NOP_INSTR, 32'h0, 0);
    step(1, 1, 0, 0, 0);
    expect_state("reset2", 32'h0, NOP_INSTR, 32'h0, 0);

    // Free run.
    step(0, 1, 0, 0, 0);
    expect_state("run1", 32'h4, 32'h2001_0005, 32'h4, 1);
    step(0, 1, 0, 0, 0);
    expect_state("run2", 32'h8, 32'h2002_000A, 32'h8, 1);

    // Load-use stall at PC=8 for two cycles.
    step(0, 0, 1, 0, 0);
    expect_state("stall1", 32'h8, 32'h2002_000A, 32'h8, 1);
    step(0, 0, 1, 0, 0);
    expect_state("stall2", 32'h8, 32'h2002_000A, 32'h8, 1);
    step(0, 1, 0, 0, 0);
    expect_state("release", 32'hC, 32'h0022_1820, 32'hC, 1);

    // Taken branch at PC=C.
    step(0, 1, 0, 1, 32'h0000_0040);
    expect_state("branch", 32'h40, NOP_INSTR, 32'h0, 0);
    step(0, 1, 0, 0, 0);
    expect_state("branch_fetch", 32'h44, mem_word(32'h40), 32'h44, 1);

    // Branch during stall: low bits of target cleared, stall discarded.
    step(0, 0, 1, 1, 32'h0000_0102);
    expect_state("branch_stall", 32'h100, NOP_INSTR, 32'h0, 0);

    // Wrap-around.
    step(0, 1, 0, 1, 32'hFFFF_FFFC);
    expect_state("wrap_br", 32'hFFFF_FFFC, NOP_INSTR, 32'h0, 0);
    step(0, 1, 0, 0, 0);
    expect_state("wrap", 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1);

    // Mixed: PC advances while IF/ID holds (skip), then re-latch in place.
    step(0, 1, 0, 0, 0);
    expect_state("pre_mix", 32'h4, 32'h2001_0005, 32'h4, 1);
    step(0, 1, 1, 0, 0);
    expect_state("skip", 32'h8, 32'h2001_0005, 32'h4, 1);
    step(0, 0, 0, 0, 0);
    expect_state("relatch1", 32'h8, 32'h0022_1820, 32'hC, 1);
    step(0, 0, 0, 0, 0);
    expect_state("relatch2", 32'h8, 32'h0022_1820, 32'hC, 1);

    // Mid-operation reset overriding a branch.
    step(1, 1, 0, 1, 32'h0000_0200);
    expect_state("mid_reset", RESET_PC, NOP_INSTR, 32'h0, 0);
    step(0, 1, 0, 0, 0);
    expect_state("after_reset", 32'h4, 32'h2001_0005, 32'h4, 1);

    // Randomized phase, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic        r, pcw, frz, src;
      logic [31:0] ba;
      int unsigned mode;
      r    = ($urandom_range(0, 99) == 0);
      src  = ($urandom_range(0, 7) == 0);
      mode = $urandom_range(0, 5);
      case (mode)
        0:       begin pcw = 1'b0; frz = 1'b1; end
        1:       begin pcw = $urandom_range(0, 1) != 0; frz = $urandom_range(0, 1) != 0; end
        default: begin pcw = 1'b1; frz = 1'b0; end
      endcase
      ba = $urandom();
      if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else if ($urandom_range(0, 3) == 0) ba = $urandom() & 32'h0000_001F;
      step(r, pcw, frz, src, ba);
    end

    step(0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
